// File: rtl/stream_pkg.sv
// Shared types and widths for the stream deframer slice.
package stream_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } deframe_state_t;

    localparam int unsigned SYNC_LEN_W = 8;

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry registered output stage: holds a byte plus last flag until the consumer takes it.
module stream_reg_slice
    import stream_pkg::*;
#(
    parameter int unsigned DATA_W = SYNC_LEN_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              r_valid;

    // A load in the same cycle as a drain keeps valid high with no bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_last  <= i_last;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_valid = r_valid;

endmodule

// File: rtl/stream_deframer.sv
// Extracts length-prefixed frames following a sync detect and forwards only the payload bytes.
module stream_deframer
    import stream_pkg::*;
#(
    parameter int unsigned MAX_LEN = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [SYNC_LEN_W-1:0] i_m_data,
    input  logic                  i_m_valid,
    output logic                  o_m_ready,
    input  logic                  i_sync,
    output logic [SYNC_LEN_W-1:0] o_s_data,
    output logic                  o_s_valid,
    output logic                  o_s_last,
    input  logic                  i_s_ready,
    output logic                  o_len_err,
    output logic [CNT_W-1:0]      o_frame_count
);

    deframe_state_t        r_state;
    deframe_state_t        w_state_nxt;
    logic [SYNC_LEN_W-1:0] r_remain;
    logic                  r_len_err;
    logic [CNT_W-1:0]      r_frame_count;

    logic w_len_ok;
    logic w_hdr;
    logic w_pl_ready;
    logic w_load;
    logic w_load_last;
    logic w_out_xfer;

    assign w_len_ok    = (i_m_data != '0) && (32'(i_m_data) <= MAX_LEN);
    assign w_hdr       = (r_state == HUNT) && i_m_valid && i_sync;
    assign w_pl_ready  = !o_s_valid || i_s_ready;
    assign w_load      = (r_state == PAYLOAD) && i_m_valid && w_pl_ready;
    assign w_load_last = (r_remain == SYNC_LEN_W'(1));
    assign w_out_xfer  = o_s_valid && i_s_ready;

    // HUNT always accepts; PAYLOAD accepts only when the output stage can take the byte.
    always_comb begin
        o_m_ready   = 1'b1;
        w_state_nxt = r_state;
        case (r_state)
            HUNT: begin
                if (w_hdr && w_len_ok) begin
                    w_state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                o_m_ready = w_pl_ready;
                if (w_load && w_load_last) begin
                    w_state_nxt = HUNT;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= HUNT;
            r_remain      <= '0;
            r_len_err     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_len_err <= w_hdr && !w_len_ok;
            if (w_hdr && w_len_ok) begin
                r_remain <= i_m_data;
            end else if (w_load) begin
                r_remain <= r_remain - SYNC_LEN_W'(1);
            end
            if (w_out_xfer && o_s_last) begin
                r_frame_count <= r_frame_count + CNT_W'(1);
            end
        end
    end

    stream_reg_slice #(
        .DATA_W (SYNC_LEN_W)
    ) u_out_slice (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_data  (i_m_data),
        .i_last  (w_load_last),
        .i_ready (i_s_ready),
        .o_data  (o_s_data),
        .o_last  (o_s_last),
        .o_valid (o_s_valid)
    );

    assign o_len_err     = r_len_err;
    assign o_frame_count = r_frame_count;

endmodule
